// File: rtl/rp_8bit_bd_arb.sv
// Round-robin arbiter sharing the rp_8bit data-memory port between NRQ requesters.
// The grant is locked for one whole transfer, and a transfer is aborted after TMO cycles without m_ack.
module rp_8bit_bd_arb #(
  parameter int NRQ = 2,
  parameter int DAW = 13,
  parameter int DW  = 8,
  parameter int TMO = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NRQ-1:0]     s_req,
  input  logic [NRQ-1:0]     s_wen,
  input  logic [NRQ*DAW-1:0] s_adr,
  input  logic [NRQ*DW-1:0]  s_wdt,
  output logic [DW-1:0]      s_rdt,
  output logic [NRQ-1:0]     s_ack,
  output logic               s_err,
  output logic               m_req,
  output logic               m_wen,
  output logic [DAW-1:0]     m_adr,
  output logic [DW-1:0]      m_wdt,
  input  logic [DW-1:0]      m_rdt,
  input  logic               m_ack,
  output logic [NRQ-1:0]     gnt
);

  localparam int PW = (NRQ > 1) ? $clog2(NRQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   g_reg;
  logic [NRQ-1:0]  gnt_reg;
  logic [7:0]      tcnt_reg;

  logic [PW-1:0]   win_lo;
  logic [PW-1:0]   win_hi;
  logic            any_lo;
  logic            any_hi;
  logic [PW-1:0]   win_next;
  logic [PW-1:0]   ptr_next;
  logic            busy;
  logic            timeout;
  logic            done;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    win_lo = '0;
    win_hi = '0;
    any_lo = 1'b0;
    any_hi = 1'b0;
    for (int j = NRQ - 1; j >= 0; j--) begin
      if (s_req[j]) begin
        win_lo = PW'(j);
        any_lo = 1'b1;
        if (j >= int'(ptr_reg)) begin
          win_hi = PW'(j);
          any_hi = 1'b1;
        end
      end
    end
    win_next = any_hi ? win_hi : win_lo;
  end

  assign ptr_next = (g_reg == PW'(NRQ - 1)) ? '0 : g_reg + 1'b1;
  assign busy     = (state_reg == BUSY);
  assign timeout  = (tcnt_reg == 8'(TMO - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      g_reg     <= '0;
      gnt_reg   <= '0;
      tcnt_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_lo) begin
            g_reg     <= win_next;
            gnt_reg   <= NRQ'(1) << win_next;
            tcnt_reg  <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (m_ack || timeout) begin
            ptr_reg   <= ptr_next;
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (tcnt_reg != 8'hFF) begin
            tcnt_reg <= tcnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Completion is masked while rst is low so a reset mid-transfer ends it silently.
  assign done  = busy && rst && (m_ack || timeout);
  assign s_err = busy && rst && !m_ack && timeout;
  assign s_rdt = (busy && rst && m_ack) ? m_rdt : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NRQ; gi++) begin : g_ack
      assign s_ack[gi] = done && gnt_reg[gi];
    end
  endgenerate

  assign m_req = busy;
  assign m_wen = busy && s_wen[g_reg];
  assign m_adr = busy ? s_adr[g_reg*DAW +: DAW] : '0;
  assign m_wdt = busy ? s_wdt[g_reg*DW +: DW] : '0;
  assign gnt   = gnt_reg;

endmodule
